// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory bank: access sizes and controller states.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store lane enables and replication, load select and extension,
// and alignment / size legality for a single access.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    end

    // Store data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'd0;
        o_rdata    = 32'd0;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{i_signed & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_misalign = (i_addr_lo != 2'd0);
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rword;
            end
            default: o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_bank.sv
// Single-port 32-bit data memory with byte/half/word access, fixed response latency
// and one outstanding request.
module data_mem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    dmem_state_e   r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_live;

    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_misalign;
    logic          w_err;
    logic          w_accept;
    logic [3:0]    w_be;
    logic [31:0]   w_wrep;
    logic [31:0]   w_rext;

    assign w_idx    = req_addr[AW+1:2];
    assign w_oor    = |req_addr[31:AW+2];
    assign w_err    = w_oor | w_misalign;
    assign w_accept = req_valid & req_ready;

    dmem_lane_align u_align (
        .i_size     (req_size),
        .i_signed   (req_signed),
        .i_addr_lo  (req_addr[1:0]),
        .i_wdata    (req_wdata),
        .i_rword    (r_mem[w_idx]),
        .o_be       (w_be),
        .o_wdata    (w_wrep),
        .o_rdata    (w_rext),
        .o_misalign (w_misalign)
    );

    // Contents survive reset so a store accepted before a mid-flight reset stays committed.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_accept && req_we && !w_err && w_be[b])
                r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rdata <= (req_we || w_err) ? 32'd0 : w_rext;
                        r_err   <= w_err;
                        if (LATENCY == 1) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // r_live holds req_ready low until the first edge after reset release.
    assign req_ready = (r_state == ST_IDLE) && r_live;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
